// File: rtl/config_pkg.sv
// Subset of the core configuration package; this slice reads no fields from it.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    logic        RVH;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

// File: rtl/riscv.sv
// Subset of the RISC-V package used by the shared TLB lookup controller:
// virtual-address width and the SV39 page-table-entry layout.
package riscv;
  localparam int unsigned VLEN = 64;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv39_t;
endpackage

// File: rtl/shared_tlb_lu_ctrl_pkg.sv
// Types and helpers shared by the TLB lookup controller and its arbiter.
package shared_tlb_lu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, ACK} shared_tlb_state_e;

  localparam logic RESP_ID_I = 1'b0;
  localparam logic RESP_ID_D = 1'b1;

  // Bit 0 = I, bit 1 = D; on a tie the port that did not win last time goes.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_d);
    logic [1:0] gnt;
    gnt[0] = req[0] & (~req[1] | last_d);
    gnt[1] = req[1] & (~req[0] | ~last_d);
    return gnt;
  endfunction
endpackage

// File: rtl/shared_tlb_lu_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the last-winner pointer resets to the I port
// so D wins the first tie.
module shared_tlb_lu_ctrl_rr_arb2
  import shared_tlb_lu_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  logic r_last_d;

  assign o_gnt = rr_pick(i_req, r_last_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_d <= RESP_ID_I;
    end else if (|o_gnt) begin
      r_last_d <= o_gnt[1];
    end
  end
endmodule

// File: rtl/shared_tlb_lu_ctrl.sv
// Shared SV39 TLB lookup-port controller: round-robin I/D arbitration with a
// one-cycle registered response, plus SFENCE.VMA flush sequencing.
module shared_tlb_lu_ctrl
  import shared_tlb_lu_ctrl_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
  parameter int unsigned           ASID_WIDTH = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_req_valid_i,
  output logic                    i_req_ready_o,
  input  logic [ASID_WIDTH-1:0]   i_asid_i,
  input  logic [riscv::VLEN-1:0]  i_vaddr_i,
  input  logic                    d_req_valid_i,
  output logic                    d_req_ready_o,
  input  logic [ASID_WIDTH-1:0]   d_asid_i,
  input  logic [riscv::VLEN-1:0]  d_vaddr_i,
  output logic                    resp_valid_o,
  output logic                    resp_id_o,
  output logic                    resp_hit_o,
  output riscv::pte_sv39_t        resp_content_o,
  output logic                    resp_is_2M_o,
  output logic                    resp_is_1G_o,
  output logic                    tlb_lu_access_o,
  output logic [ASID_WIDTH-1:0]   tlb_lu_asid_o,
  output logic [riscv::VLEN-1:0]  tlb_lu_vaddr_o,
  input  logic                    tlb_lu_hit_i,
  input  riscv::pte_sv39_t        tlb_lu_content_i,
  input  logic                    tlb_lu_is_2M_i,
  input  logic                    tlb_lu_is_1G_i,
  input  logic                    flush_req_i,
  input  logic [ASID_WIDTH-1:0]   flush_asid_i,
  input  logic [riscv::VLEN-1:0]  flush_vaddr_i,
  output logic                    flush_ack_o,
  output logic                    tlb_flush_o,
  output logic [ASID_WIDTH-1:0]   tlb_asid_flush_o,
  output logic [riscv::VLEN-1:0]  tlb_vaddr_flush_o,
  input  logic                    ptw_busy_i,
  output logic                    ptw_update_allow_o,
  output logic                    perf_miss_o
);
  shared_tlb_state_e        r_state;
  logic [ASID_WIDTH-1:0]    r_flush_asid;
  logic [riscv::VLEN-1:0]   r_flush_vaddr;
  logic                     r_tlb_flush;
  logic                     r_flush_ack;
  logic                     r_ptw_allow;

  logic                     r_resp_vld_p1;
  logic                     r_resp_id_p1;
  logic                     r_resp_hit_p1;
  riscv::pte_sv39_t         r_resp_content_p1;
  logic                     r_resp_2M_p1;
  logic                     r_resp_1G_p1;

  logic                     w_lu_en;
  logic [1:0]               w_req;
  logic [1:0]               w_gnt;
  logic                     w_gnt_any;
  logic                     w_unused_cfg;

  // The core configuration carries nothing this block depends on.
  assign w_unused_cfg = ^CVA6Cfg;

  // Stage p0: arbitration and lookup issue; a pending flush wins over any request.
  assign w_lu_en   = (r_state == IDLE) & ~flush_req_i;
  assign w_req     = {d_req_valid_i, i_req_valid_i} & {2{w_lu_en}};
  assign w_gnt_any = |w_gnt;

  shared_tlb_lu_ctrl_rr_arb2 u_rr_arb2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_req  (w_req),
    .o_gnt  (w_gnt)
  );

  assign i_req_ready_o   = w_gnt[0];
  assign d_req_ready_o   = w_gnt[1];
  assign tlb_lu_access_o = w_gnt_any;
  assign tlb_lu_asid_o   = w_gnt[1] ? d_asid_i  : i_asid_i;
  assign tlb_lu_vaddr_o  = w_gnt[1] ? d_vaddr_i : i_vaddr_i;

  // Stage p1: registered lookup result, exactly one cycle behind its grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_vld_p1     <= 1'b0;
      r_resp_id_p1      <= RESP_ID_I;
      r_resp_hit_p1     <= 1'b0;
      r_resp_content_p1 <= '0;
      r_resp_2M_p1      <= 1'b0;
      r_resp_1G_p1      <= 1'b0;
    end else begin
      r_resp_vld_p1 <= w_gnt_any;
      if (w_gnt_any) begin
        r_resp_id_p1      <= w_gnt[1] ? RESP_ID_D : RESP_ID_I;
        r_resp_hit_p1     <= tlb_lu_hit_i;
        r_resp_content_p1 <= tlb_lu_content_i;
        r_resp_2M_p1      <= tlb_lu_is_2M_i;
        r_resp_1G_p1      <= tlb_lu_is_1G_i;
      end
    end
  end

  assign resp_valid_o   = r_resp_vld_p1;
  assign resp_id_o      = r_resp_id_p1;
  assign resp_hit_o     = r_resp_hit_p1;
  assign resp_content_o = r_resp_content_p1;
  assign resp_is_2M_o   = r_resp_2M_p1;
  assign resp_is_1G_o   = r_resp_1G_p1;
  assign perf_miss_o    = r_resp_vld_p1 & ~r_resp_hit_p1;

  // Flush sequencer; each output register is set on entry to the state it marks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_flush_asid  <= '0;
      r_flush_vaddr <= '0;
      r_tlb_flush   <= 1'b0;
      r_flush_ack   <= 1'b0;
      r_ptw_allow   <= 1'b1;
    end else begin
      r_tlb_flush <= 1'b0;
      r_flush_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush_req_i) begin
            r_flush_asid  <= flush_asid_i;
            r_flush_vaddr <= flush_vaddr_i;
            r_ptw_allow   <= 1'b0;
            r_state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_resp_vld_p1 && !ptw_busy_i) begin
            r_tlb_flush <= 1'b1;
            r_state     <= FLUSH;
          end
        end
        FLUSH: begin
          r_flush_ack <= 1'b1;
          r_state     <= ACK;
        end
        ACK: begin
          r_ptw_allow <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_ptw_allow <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign tlb_flush_o        = r_tlb_flush;
  assign flush_ack_o        = r_flush_ack;
  assign tlb_asid_flush_o   = r_flush_asid;
  assign tlb_vaddr_flush_o  = r_flush_vaddr;
  assign ptw_update_allow_o = r_ptw_allow;
endmodule

// File: doc/shared_tlb_lu_ctrl.md
Name: shared_tlb_lu_ctrl

Overview:
- Controller in front of one shared SV39 TLB lookup port, serving the instruction-fetch requester (I) and the load/store requester (D).
- Arbitrates lookups round-robin, registers each result and returns it one cycle later tagged with the requester.
- Sequences SFENCE.VMA flushes: blocks new lookups, drains the in-flight lookup, waits for the PTW to go idle, pulses the TLB flush, then acknowledges.
- Sits between the MMU front-ends and the tlb / PTW instances.

Parameters:
- ASID_WIDTH, 1, width of the ASID fields.
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; unused fields are ignored.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- i_req_valid_i  in  1  I lookup request
- i_req_ready_o  out  1  I request granted this cycle
- i_asid_i  in  ASID_WIDTH  I ASID
- i_vaddr_i  in  riscv::VLEN  I virtual address
- d_req_valid_i  in  1  D lookup request
- d_req_ready_o  out  1  D request granted this cycle
- d_asid_i  in  ASID_WIDTH  D ASID
- d_vaddr_i  in  riscv::VLEN  D virtual address
- resp_valid_o  out  1  registered lookup result valid
- resp_id_o  out  1  result owner: 0 = I, 1 = D
- resp_hit_o  out  1  registered TLB hit
- resp_content_o  out  riscv::pte_sv39_t  registered PTE
- resp_is_2M_o  out  1  registered 2M flag
- resp_is_1G_o  out  1  registered 1G flag
- tlb_lu_access_o  out  1  lookup strobe to the TLB (drives PLRU update)
- tlb_lu_asid_o  out  ASID_WIDTH  muxed ASID
- tlb_lu_vaddr_o  out  riscv::VLEN  muxed vaddr
- tlb_lu_hit_i  in  1  TLB hit
- tlb_lu_content_i  in  riscv::pte_sv39_t  TLB content
- tlb_lu_is_2M_i  in  1  TLB 2M flag
- tlb_lu_is_1G_i  in  1  TLB 1G flag
- flush_req_i  in  1  SFENCE.VMA request; level, held until ack
- flush_asid_i  in  ASID_WIDTH  rs2 ASID (0 = all)
- flush_vaddr_i  in  riscv::VLEN  rs1 vaddr (0 = all)
- flush_ack_o  out  1  one-cycle flush-complete pulse
- tlb_flush_o  out  1  flush strobe to the TLB
- tlb_asid_flush_o  out  ASID_WIDTH  latched flush ASID
- tlb_vaddr_flush_o  out  riscv::VLEN  latched flush vaddr
- ptw_busy_i  in  1  PTW walk in progress
- ptw_update_allow_o  out  1  PTW may write the TLB
- perf_miss_o  out  1  one-cycle pulse per registered miss

Behaviour:
- Reset: every output 0 except ptw_update_allow_o = 1. FSM = IDLE. rr_last_q = I, so D wins the first tie. Response register is invalid.
- FSM IDLE:
  - Grant only when flush_req_i = 0.
  - One valid requester: grant it.
  - Both valid: grant the one not in rr_last_q; update rr_last_q on every grant.
  - ready_o is combinational and high only for the granted port.
  - tlb_lu_access_o = grant; the muxed ASID/vaddr come from the granted port (the I port when there is no grant).
- Response: in the cycle after a grant, resp_valid_o = 1 with the TLB outputs and resp_id_o registered from the grant cycle. Latency is exactly 1 cycle. One lookup per cycle with no bubbles. No backpressure on responses.
- perf_miss_o = resp_valid_o & ~resp_hit_o.
- Flush:
  - IDLE with flush_req_i = 1: latch flush_asid_i and flush_vaddr_i, enter DRAIN, and issue no grant that cycle. A request arriving in the same cycle as flush_req_i loses.
  - DRAIN: hold until resp_valid_o = 0 and ptw_busy_i = 0, then enter FLUSH.
  - FLUSH: tlb_flush_o = 1 for exactly one cycle with the latched ASID/vaddr, then enter ACK.
  - ACK: flush_ack_o = 1 for one cycle, then enter IDLE.
  - If flush_req_i is still high in the IDLE cycle after ACK, that is a new flush; requesters must drop it on ack.
- ptw_update_allow_o = 1 only in IDLE. An update and a lookup in the same IDLE cycle are legal.
- Reset asserted mid-flush: FSM returns to IDLE with no ack and no flush pulse.
- Requests that are not granted must hold valid/addr stable; the controller keeps no queue.

Decomposition:
- Local typedef shared_tlb_state_e {IDLE, DRAIN, FLUSH, ACK}; no shared-package content beyond riscv::pte_sv39_t and riscv::VLEN.
- Optional sub-module rr_arb2 (2-input round-robin: req[1:0], gnt[1:0], last-pointer flop); inline is acceptable.

Test Plan:
- Only I valid, vaddr 0x4000_1000, TLB hit -> i_req_ready_o high same cycle; next cycle resp_valid_o = 1, resp_id_o = 0, resp_hit_o = 1.
- I and D both valid for 4 cycles after reset -> grants D, I, D, I; responses trail by one cycle with ids 1, 0, 1, 0.
- flush_req_i with asid 0, vaddr 0, lookup in flight, ptw_busy_i high for 3 cycles -> no grants, tlb_flush_o pulses once after ptw_busy_i falls, flush_ack_o one cycle later.
- flush_req_i and d_req_valid_i rise in the same cycle -> d_req_ready_o stays 0 until after flush_ack_o; D is then granted in the first IDLE cycle.
- TLB miss on D -> resp_hit_o = 0, perf_miss_o pulse; ptw_update_allow_o = 0 throughout DRAIN/FLUSH/ACK.
- rst_ni asserted while in DRAIN -> all outputs 0, ptw_update_allow_o = 1, no flush_ack_o after release.
